// File: rtl/key_conditioner.sv
// Input stage for the digital clock: synchronises, debounces and pulse-shapes
// four active-low keys and one active-high mode button, with hold-to-repeat.
module key_conditioner #(
  parameter int         CNT_W         = 25,
  parameter int         DEB_CYCLES    = 1000000,
  parameter int         REPEAT_DELAY  = 25000000,
  parameter int         REPEAT_PERIOD = 5000000,
  parameter logic [3:0] REPEAT_MASK   = 4'b0111
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [3:0] K,
  input  logic       trans,
  output logic [3:0] key_press,
  output logic       trans_press,
  output logic [3:0] key_held,
  output logic       trans_held
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REPEAT,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  // Channel 4 is trans: idles low and never repeats.
  localparam logic [4:0] IDLE_LVL_ALL = 5'b01111;
  localparam logic [4:0] RPT_EN_ALL   = {1'b0, REPEAT_MASK};

  logic [4:0] raw;
  logic [4:0] press_all;
  logic [4:0] held_all;

  assign raw = {trans, K};

  // Each channel's FSM is observable hierarchically as g_chan[i].state.
  for (genvar ch = 0; ch < 5; ch++) begin : g_chan
    localparam logic IDLE_LVL = IDLE_LVL_ALL[ch];
    localparam logic RPT_EN   = RPT_EN_ALL[ch];

    logic             sync1;
    logic             sync2;
    logic             asserted;
    logic             press_q;
    logic             held_q;
    logic [CNT_W-1:0] cnt;
    state_t           state;

    assign asserted = sync2 ^ IDLE_LVL;

    always_ff @(posedge CLOCK_50) begin
      if (!reset) begin
        sync1   <= IDLE_LVL;
        sync2   <= IDLE_LVL;
        state   <= IDLE;
        cnt     <= '0;
        press_q <= 1'b0;
        held_q  <= 1'b0;
      end else begin
        sync1   <= raw[ch];
        sync2   <= sync1;
        press_q <= 1'b0;
        case (state)
          IDLE: begin
            if (asserted) begin
              state <= PRESS_WAIT;
              cnt   <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!asserted) begin
              state <= IDLE;
            end else if (cnt == DEB_LAST) begin
              state   <= HELD;
              press_q <= 1'b1;
              held_q  <= 1'b1;
              cnt     <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HELD: begin
            // Without repeat the timer simply parks until release.
            if (!asserted) begin
              state <= RELEASE_WAIT;
              cnt   <= '0;
            end else if (RPT_EN) begin
              if (cnt == DLY_LAST) begin
                state   <= REPEAT;
                press_q <= 1'b1;
                cnt     <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          REPEAT: begin
            // Release wins over a coinciding terminal count.
            if (!asserted) begin
              state <= RELEASE_WAIT;
              cnt   <= '0;
            end else if (cnt == PER_LAST) begin
              press_q <= 1'b1;
              cnt     <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RELEASE_WAIT: begin
            if (asserted) begin
              state <= HELD;
              cnt   <= '0;
            end else if (cnt == DEB_LAST) begin
              state  <= IDLE;
              held_q <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign press_all[ch] = press_q;
    assign held_all[ch]  = held_q;
  end

  assign key_press   = press_all[3:0];
  assign trans_press = press_all[4];
  assign key_held    = held_all[3:0];
  assign trans_held  = held_all[4];

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/repeat timings;
// press pulses are logged per edge and compared against hand-derived edges.
module tb_key_conditioner;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] K     = 4'hF;
  logic       trans = 1'b0;
  logic [3:0] key_press;
  logic       trans_press;
  logic [3:0] key_held;
  logic       trans_held;

  int edge_n   = 0;
  int checks   = 0;
  int failures = 0;

  logic [31:0] log_q[$];
  logic [31:0] exp_q[$];

  key_conditioner #(
    .CNT_W        (8),
    .DEB_CYCLES   (DEB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP),
    .REPEAT_MASK  (4'b0111)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .K          (K),
    .trans      (trans),
    .key_press  (key_press),
    .trans_press(trans_press),
    .key_held   (key_held),
    .trans_held (trans_held)
  );

  // Clock and edge counter: after the k-th rising edge edge_n == k.
  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Pulse log entry = edge*8 + channel (channel 4 = trans).
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++)
      if (key_press[c] === 1'b1) log_q.push_back(32'(edge_n * 8 + c));
    if (trans_press === 1'b1) log_q.push_back(32'(edge_n * 8 + 4));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_pulses(input string tag, input int ch);
    logic [31:0] got_q[$];
    foreach (log_q[i])
      if (int'(log_q[i][2:0]) == ch) got_q.push_back(log_q[i] >> 3);
    check($sformatf("%s_count", tag), 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check($sformatf("%s_edge%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  task automatic go(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({key_press, trans_press, key_held, trans_held});
  endfunction

  initial begin
    int n;
    int m;
    int r;

    // Reset held low while inputs toggle.
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("reset_outputs", all_outs(), 32'd0);
      K     = 4'($urandom_range(0, 15));
      trans = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    reset = 1'b1;
    K     = 4'hF;
    trans = 1'b0;
    log_q.delete();
    go(edge_n + 20);
    check("idle_no_pulse", 32'(log_q.size()), 32'd0);
    check("idle_held", all_outs(), 32'd0);

    // Clean press and release on K[0].
    log_q.delete();
    n    = edge_n + 1;
    K[0] = 1'b0;
    go(n + 5);
    check("press_held_early", 32'(key_held[0]), 32'd0);
    check("press_pulse_early", 32'(key_press[0]), 32'd0);
    go(n + 6);
    check("press_held_rise", 32'(key_held[0]), 32'd1);
    check("press_pulse_high", 32'(key_press[0]), 32'd1);
    go(n + 7);
    check("press_pulse_width", 32'(key_press[0]), 32'd0);
    K[0] = 1'b1;
    m    = n + 8;
    go(m + 5);
    check("release_held_late", 32'(key_held[0]), 32'd1);
    go(m + 6);
    check("release_held_fall", 32'(key_held[0]), 32'd0);
    go(m + 10);
    exp_q.delete();
    exp_q.push_back(32'(n + 6));
    check_pulses("clean_press", 0);

    // Bounce on K[1] without ever reaching the debounce count.
    log_q.delete();
    for (int rep = 0; rep < 5; rep++) begin
      K[1] = 1'b0;
      repeat (3) begin
        @(negedge clk);
        check("bounce_held_low", 32'(key_held[1]), 32'd0);
      end
      K[1] = 1'b1;
      repeat (2) begin
        @(negedge clk);
        check("bounce_held_low", 32'(key_held[1]), 32'd0);
      end
    end
    go(edge_n + 10);
    exp_q.delete();
    check_pulses("bounce_reject", 1);

    // Release bounce after an accepted press.
    log_q.delete();
    n    = edge_n + 1;
    K[1] = 1'b0;
    go(n + 6);
    check("bounce_press_held", 32'(key_held[1]), 32'd1);
    go(n + 7);
    for (int rep = 0; rep < 5; rep++) begin
      K[1] = 1'b1;
      repeat (2) begin
        @(negedge clk);
        check("bounce_held_high", 32'(key_held[1]), 32'd1);
      end
      K[1] = 1'b0;
      repeat (3) begin
        @(negedge clk);
        check("bounce_held_high", 32'(key_held[1]), 32'd1);
      end
    end
    K[1] = 1'b1;
    go(edge_n + 12);
    check("bounce_final_release", 32'(key_held[1]), 32'd0);
    exp_q.delete();
    exp_q.push_back(32'(n + 6));
    check_pulses("bounce_after_press", 1);

    // Auto-repeat on K[1]: 40 low cycles.
    log_q.delete();
    n    = edge_n + 1;
    K[1] = 1'b0;
    go(n + 39);
    K[1] = 1'b1;
    go(n + 52);
    exp_q.delete();
    exp_q.push_back(32'(n + 6));
    for (int k = 0; k < 9; k++) exp_q.push_back(32'(n + 16 + 3 * k));
    check_pulses("repeat_k1", 1);

    // Same stimulus on K[3], where repeat is masked off.
    log_q.delete();
    n    = edge_n + 1;
    K[3] = 1'b0;
    go(n + 39);
    check("norepeat_held", 32'(key_held[3]), 32'd1);
    K[3] = 1'b1;
    go(n + 52);
    exp_q.delete();
    exp_q.push_back(32'(n + 6));
    check_pulses("repeat_k3", 3);

    // trans and K[2] together.
    log_q.delete();
    n     = edge_n + 1;
    trans = 1'b1;
    K[2]  = 1'b0;
    go(n + 6);
    check("simul_trans_held", 32'(trans_held), 32'd1);
    check("simul_k2_held", 32'(key_held[2]), 32'd1);
    go(n + 7);
    trans = 1'b0;
    K[2]  = 1'b1;
    go(n + 20);
    exp_q.delete();
    exp_q.push_back(32'(n + 6));
    check_pulses("simul_trans", 4);
    check_pulses("simul_k2", 2);

    // Short trans blip is rejected.
    log_q.delete();
    trans = 1'b1;
    @(negedge clk);
    @(negedge clk);
    trans = 1'b0;
    go(edge_n + 12);
    exp_q.delete();
    check_pulses("short_trans", 4);
    check("short_trans_held", 32'(trans_held), 32'd0);

    // Reset while K[0] is repeating, key kept low through it.
    n    = edge_n + 1;
    K[0] = 1'b0;
    go(n + 17);
    reset = 1'b0;
    r     = n + 18;
    go(r);
    check("midrst_outputs", all_outs(), 32'd0);
    reset = 1'b1;
    log_q.delete();
    go(r + 6);
    check("midrst_held_early", 32'(key_held[0]), 32'd0);
    go(r + 7);
    check("midrst_held_rise", 32'(key_held[0]), 32'd1);
    go(r + 8);
    exp_q.delete();
    exp_q.push_back(32'(r + 7));
    check_pulses("midrst_repress", 0);
    K[0] = 1'b1;
    go(edge_n + 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Upstream input stage of the digital clock. It takes the four raw active-low push buttons (K0–K3) and the raw active-high mode button (trans) and delivers what the clock/setting core consumes: each input is synchronised, debounced, and turned into single-cycle press pulses plus a clean held level. It also provides hold-to-repeat pulses on the increment keys, so a held key steps the set-up value at a fixed rate.

## Interface
Parameters:
- CNT_W, 25, width of each per-channel timer; must hold max(DEB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)
- DEB_CYCLES, 1000000, consecutive stable cycles needed to accept a press or release (20 ms at 50 MHz); ≥1
- REPEAT_DELAY, 25000000, cycles from accepted press to first repeat pulse; ≥1
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses; ≥1
- REPEAT_MASK, 4'b0111, bit i=1 enables auto-repeat on K[i]; trans never repeats

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- K  in  4  raw push buttons, active-low, asynchronous to CLOCK_50
- trans  in  1  raw mode button, active-high, asynchronous
- key_press  out  4  one-cycle pulse per accepted press or repeat, per key
- trans_press  out  1  one-cycle pulse per accepted trans press
- key_held  out  4  debounced pressed level, 1 = pressed
- trans_held  out  1  debounced trans level

## Operation
- Five independent channels; trans is channel 4 with inverted polarity and repeat disabled. "Asserted" means K[i]=0 or trans=1 after synchronisation.
- Per channel: 2-flop synchroniser, timer cnt[CNT_W-1:0], FSM {IDLE, PRESS_WAIT, HELD, REPEAT, RELEASE_WAIT}.
- IDLE: synced asserted -> PRESS_WAIT, cnt=0.
- PRESS_WAIT: synced deasserted -> IDLE (bounce rejected, no pulse). Else if cnt==DEB_CYCLES-1 -> HELD, press pulse, held<=1, cnt=0; else cnt++.
- HELD: deasserted -> RELEASE_WAIT, cnt=0. Else if repeat enabled: cnt==REPEAT_DELAY-1 -> REPEAT, pulse, cnt=0; else cnt++. Repeat disabled: cnt frozen.
- REPEAT: deasserted -> RELEASE_WAIT, cnt=0. Else cnt==REPEAT_PERIOD-1 -> pulse, cnt=0; else cnt++.
- RELEASE_WAIT: asserted again -> HELD, cnt=0, no pulse (release bounce). Else cnt==DEB_CYCLES-1 -> IDLE, held<=0; else cnt++.
- Release takes priority over a coinciding repeat terminal count: no pulse.
- Simultaneous activity on several channels is independent; multiple pulses in the same cycle are legal.
- Reset (reset=0 at an edge): all FSMs IDLE, cnt=0, K synchroniser flops to 1, trans synchroniser flops to 0, all outputs 0. Reset mid-operation discards state; a key still held after reset is re-accepted as a new press.

## Timing
- All outputs registered; reset value 0 on every output.
- Edge N = first edge sampling raw input asserted, input stable after that: FSM leaves IDLE at N+2; press pulse and held rise at edge N+2+DEB_CYCLES; pulse is exactly one cycle wide.
- Repeat pulses at press edge + REPEAT_DELAY, then every REPEAT_PERIOD edges.
- Release at edge M, stable: held falls at M+2+DEB_CYCLES.
- Assertion shorter than DEB_CYCLES+1 synced cycles yields no output activity.

## Test plan
Use DEB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, REPEAT_MASK=4'b0111.
- Reset: reset=0 for 10 cycles while toggling K and trans -> all outputs 0 throughout; after reset=1 with inputs idle, no pulse.
- Clean press: K[0]=0 from edge N for 8 cycles, then 1 from edge M -> key_press[0] high only after edge N+6; key_held[0] rises at N+6, falls at M+6; no repeat pulse.
- Bounce: K[1] low 3 cycles / high 2 cycles, repeated 5 times -> no key_press, key_held stays 0; same bouncing after an accepted press keeps key_held=1 with no extra pulse.
- Auto-repeat: K[1]=0 for 40 cycles from edge N -> exactly 10 key_press[1] pulses at N+6, N+16, N+19, … N+40; same stimulus on K[3] -> exactly 1 pulse.
- Simultaneous: trans=1 and K[2]=0 on the same edge for 8 cycles -> trans_press and key_press[2] on the same cycle; trans=1 for only 2 cycles -> nothing.
- Reset mid-repeat: K[0] held in REPEAT, reset=0 for 1 cycle -> all outputs 0 next cycle; with K[0] still low, a new key_press[0] arrives 6 edges after reset returns to 1.
